// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-fetch bus bundle: memory read port plus the valid/ready pop port toward the core.
// The master modport is the prefetcher's view; slave is the memory/core side.
interface fetch_prefetch_unit_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_SIZE  = 32
);
  logic                  mem_r_en;
  logic [ADDR_WIDTH-1:0] mem_r_adrs;
  logic                  mem_r_valid;
  logic [DATA_SIZE-1:0]  mem_data_out;
  logic                  ir_valid;
  logic                  ir_ready;
  logic [DATA_SIZE-1:0]  ir_data;
  logic [ADDR_WIDTH-1:0] ir_pc;

  modport master (
    output mem_r_en, mem_r_adrs, ir_valid, ir_data, ir_pc,
    input  mem_r_valid, mem_data_out, ir_ready
  );

  modport slave (
    input  mem_r_en, mem_r_adrs, ir_valid, ir_data, ir_pc,
    output mem_r_valid, mem_data_out, ir_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// In-order instruction prefetcher: PC, credit-limited issue, DEPTH-entry buffer and branch flush
// that discards responses to requests issued before the redirect.
module fetch_prefetch_unit #(
  parameter int                    ADDR_WIDTH = 11,
  parameter int                    DATA_SIZE  = 32,
  parameter int                    DEPTH      = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      branch_valid,
  input  logic [ADDR_WIDTH-1:0]     branch_address,
  fetch_prefetch_unit_if.master     bus,
  output logic [$clog2(DEPTH):0]    occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = PW + 2;
  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         inflight_q, inflight_d, discard_q, discard_d;
  logic                  run_q;

  logic [DATA_SIZE-1:0]  data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

  logic [IW:0] committed;
  logic        resp, issue, push, drop, pop;

  // Buffered words plus requests whose responses will be kept; this is the issue credit.
  assign committed = (IW+1)'(count_q) + (IW+1)'(inflight_q) - (IW+1)'(discard_q);

  // A strobe with nothing outstanding is a protocol violation and is ignored outright.
  assign resp  = bus.mem_r_valid && (inflight_q != '0);
  assign issue = run_q && !branch_valid && (committed < DEPTH_W);
  assign push  = resp && (discard_q == '0) && !branch_valid;
  assign drop  = resp && (discard_q != '0) && !branch_valid;
  assign pop   = bus.ir_valid && bus.ir_ready;

  assign bus.mem_r_en   = issue;
  assign bus.mem_r_adrs = pc_q;
  assign bus.ir_valid   = (count_q != '0) && !branch_valid;
  assign bus.ir_data    = (count_q != '0) ? data_mem[rd_ptr_q] : '0;
  assign bus.ir_pc      = (count_q != '0) ? addr_mem[rd_ptr_q] : '0;
  assign occupancy      = count_q;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + IW'(issue) - IW'(resp);

    if (branch_valid) begin
      pc_d      = branch_address;
      resp_pc_d = branch_address;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      discard_d = inflight_q - IW'(resp);
    end else begin
      if (issue) pc_d = pc_q + ADDR_WIDTH'(1);
      if (drop)  discard_d = discard_q - IW'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + ADDR_WIDTH'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      run_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      run_q      <= 1'b1;
    end
  end

  // NOTE: the storage array is not reset; outputs are masked to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.mem_data_out;
      addr_mem[wr_ptr_q] <= resp_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit: a queue-based model of the instruction stream and
// of outstanding memory requests predicts every output each cycle.
module tb_fetch_prefetch_unit;
  localparam int AW = 11;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam int AMASK = (1 << AW) - 1;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   branch_valid;
  logic [AW-1:0]          branch_address;
  logic [$clog2(DEPTH):0] occupancy;

  fetch_prefetch_unit_if #(.ADDR_WIDTH(AW), .DATA_SIZE(DW)) bus ();

  fetch_prefetch_unit #(
    .ADDR_WIDTH(AW), .DATA_SIZE(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .resetn(resetn), .branch_valid(branch_valid),
    .branch_address(branch_address), .bus(bus.master), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; bit live; int due; } req_t;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem_w [1 << AW];
  req_t out_q[$];
  int   buf_q[$];
  int   iss_log[$];
  int   pop_log[$];
  int   live_cnt, exp_pc, cyc;
  bit   started;
  bit   obs_en, obs_valid;

  bit mem_hold, force_br, force_spur;
  int resp_pct, lat_max, ready_mode, br_pct, force_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, then advance the model past the rising edge.
  task automatic cycle();
    bit br, resp, ready, exp_en, exp_valid, pop;
    int lat;
    req_t r;
    br = force_br || (br_pct > 0 && $urandom_range(99) < br_pct);
    branch_valid = br;
    if (force_br) branch_address = AW'(force_addr);
    else if ($urandom_range(3) == 0) branch_address = AW'(AMASK - int'($urandom_range(2)));
    else branch_address = AW'($urandom);
    ready = (ready_mode == 2) ? ($urandom_range(1) == 1) : (ready_mode == 1);
    bus.ir_ready = ready;
    resp = !mem_hold && out_q.size() > 0 && out_q[0].due <= cyc && $urandom_range(99) < resp_pct;
    bus.mem_r_valid = resp || (force_spur && out_q.size() == 0);
    bus.mem_data_out = resp ? mem_w[out_q[0].addr] : DW'($urandom);

    @(negedge clk);
    exp_en    = started && !br && (buf_q.size() + live_cnt < DEPTH);
    exp_valid = (buf_q.size() != 0) && !br;
    check("mem_r_en", bus.mem_r_en, exp_en);
    check("mem_r_adrs", bus.mem_r_adrs, exp_pc);
    check("ir_valid", bus.ir_valid, exp_valid);
    check("occupancy", occupancy, buf_q.size());
    if (buf_q.size() != 0) begin
      check("ir_pc", bus.ir_pc, buf_q[0]);
      check("ir_data", bus.ir_data, mem_w[buf_q[0]]);
    end
    obs_en    = bus.mem_r_en;
    obs_valid = bus.ir_valid;
    if (bus.mem_r_en) iss_log.push_back(int'(bus.mem_r_adrs));
    if (bus.ir_valid && ready) pop_log.push_back(int'(bus.ir_pc));
    pop = exp_valid && ready;

    @(posedge clk);
    #1;
    cyc++;
    if (pop) void'(buf_q.pop_front());
    if (resp) begin
      r = out_q.pop_front();
      if (r.live) begin
        live_cnt--;
        if (!br) buf_q.push_back(r.addr);
      end
    end
    if (exp_en) begin
      lat = int'($urandom_range(lat_max, 1));
      out_q.push_back('{addr: exp_pc, live: 1'b1, due: cyc + lat - 1});
      live_cnt++;
      exp_pc = (exp_pc + 1) & AMASK;
    end
    if (br) begin
      foreach (out_q[i]) out_q[i].live = 1'b0;
      live_cnt = 0;
      buf_q.delete();
      exp_pc = int'(branch_address);
    end
    started = 1'b1;
  endtask

  // Hold reset for n cycles with noise on the inputs; memory forgets everything outstanding.
  task automatic do_reset(input int n);
    resetn = 1'b0;
    out_q.delete();
    buf_q.delete();
    live_cnt = 0;
    exp_pc   = int'(RESET_PC);
    started  = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mem_r_valid  = 1'b1;
      bus.ir_ready     = 1'b1;
      bus.mem_data_out = DW'($urandom);
      branch_valid     = 1'b0;
      @(negedge clk);
      check("rst_mem_r_en", bus.mem_r_en, 0);
      check("rst_ir_valid", bus.ir_valid, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_ir_data", bus.ir_data, 0);
      check("rst_ir_pc", bus.ir_pc, 0);
      @(posedge clk);
      #1;
    end
    bus.mem_r_valid = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int wrap_exp[3];
    wrap_exp = '{'h7FE, 'h7FF, 'h000};
    foreach (mem_w[i]) mem_w[i] = $urandom;
    cyc = 0; live_cnt = 0; exp_pc = 0; started = 1'b0;
    mem_hold = 1'b0; force_br = 1'b0; force_spur = 1'b0; force_addr = 0;
    resp_pct = 100; lat_max = 1; ready_mode = 0; br_pct = 0;
    resetn = 1'b0; branch_valid = 1'b0; branch_address = '0;
    bus.ir_ready = 1'b0; bus.mem_r_valid = 1'b0; bus.mem_data_out = '0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Fill with the core stalled.
    iss_log.delete();
    repeat (14) cycle();
    check("fill_issues", iss_log.size(), 8);
    foreach (iss_log[i]) check("fill_adrs", iss_log[i], i);
    check("fill_occ", occupancy, 8);
    check("fill_ir_pc", bus.ir_pc, 0);
    check("fill_valid", obs_valid, 1);
    check("fill_en", obs_en, 0);

    // Streaming: one issue and one pop per cycle once settled.
    ready_mode = 1;
    repeat (4) cycle();
    iss_log.delete();
    pop_log.delete();
    repeat (20) cycle();
    check("stream_issues", iss_log.size(), 20);
    check("stream_pops", pop_log.size(), 20);
    foreach (pop_log[i]) check("stream_pop_pc", pop_log[i], 4 + i);
    foreach (iss_log[i]) check("stream_iss_pc", iss_log[i], 11 + i);
    check("stream_occ", occupancy, 6);

    // Branch with 3 requests in flight and 4 entries buffered.
    do_reset(1);
    ready_mode = 0;
    mem_hold = 1'b1;
    for (int i = 0; i < 40 && live_cnt < 8; i++) cycle();
    mem_hold = 1'b0;
    for (int i = 0; i < 40 && buf_q.size() < 5; i++) cycle();
    mem_hold = 1'b1;
    ready_mode = 1;
    cycle();
    ready_mode = 0;
    check("br_pre_occ", occupancy, 4);
    force_br = 1'b1; force_addr = 'h100;
    cycle();
    force_br = 1'b0;
    check("br_post_occ", occupancy, 0);
    mem_hold = 1'b0;
    for (int i = 0; i < 40 && !obs_valid; i++) cycle();
    check("br_target_seen", obs_valid, 1);
    check("br_first_pc", bus.ir_pc, 'h100);
    check("br_first_data", bus.ir_data, mem_w['h100]);

    // Branch colliding with a response and a pop.
    ready_mode = 1;
    repeat (6) cycle();
    check("coll_pre_nonempty", occupancy != 0, 1);
    force_br = 1'b1; force_addr = 'h200;
    cycle();
    force_br = 1'b0;
    check("coll_br_valid", obs_valid, 0);
    check("coll_post_occ", occupancy, 0);
    iss_log.delete();
    pop_log.delete();
    repeat (6) cycle();
    check("coll_pops", pop_log.size() > 0, 1);
    if (pop_log.size() > 0) check("coll_first_pop", pop_log[0], 'h200);
    if (iss_log.size() > 0) check("coll_first_iss", iss_log[0], 'h200);

    // Held branch with changing target, then PC wrap.
    force_br = 1'b1;
    force_addr = 'h300; cycle();
    force_addr = 'h310; cycle();
    force_addr = 'h7FE; cycle();
    force_br = 1'b0;
    check("hold_occ", occupancy, 0);
    check("hold_pc", bus.mem_r_adrs, 'h7FE);
    iss_log.delete();
    pop_log.delete();
    repeat (8) cycle();
    check("wrap_iss_n", iss_log.size() >= 3, 1);
    check("wrap_pop_n", pop_log.size() >= 3, 1);
    for (int i = 0; i < 3 && i < iss_log.size(); i++) check("wrap_iss", iss_log[i], wrap_exp[i]);
    for (int i = 0; i < 3 && i < pop_log.size(); i++) check("wrap_pop", pop_log[i], wrap_exp[i]);

    // Reset with requests in flight, then spurious strobes after release.
    mem_hold = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 40 && out_q.size() < 5; i++) cycle();
    check("rst_pre_inflight", out_q.size() >= 5, 1);
    do_reset(3);
    force_spur = 1'b1;
    iss_log.delete();
    cycle();
    cycle();
    force_spur = 1'b0;
    check("spur_occ", occupancy, 0);
    mem_hold = 1'b0;
    repeat (4) cycle();
    check("spur_iss_n", iss_log.size() > 0, 1);
    if (iss_log.size() > 0) check("spur_first_adrs", iss_log[0], RESET_PC);

    // Random soak: variable latency, random pops and random (sometimes held) branches.
    ready_mode = 2; lat_max = 3; resp_pct = 75; br_pct = 4;
    repeat (3000) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Single-clock instruction prefetcher. It combines the program counter with a parametrised instruction buffer and adds branch flush, which the earlier PC-plus-FIFO pairing lacks. It issues in-order read requests to the memory instruction port, buffers up to DEPTH returned words, and presents them to the core through a valid/ready pop interface. On a branch it redirects the PC, clears the buffer and discards any stale in-flight responses.

Parameters:
ADDR_WIDTH, 11, instruction address width; the PC wraps modulo 2^ADDR_WIDTH.
DATA_SIZE, 32, instruction word width.
DEPTH, 8, buffer entries; power of two, at least 2.
RESET_PC, 0, PC value after reset.

Ports:
clk  input  1  system clock.
resetn  input  1  asynchronous active-low reset.
branch_valid  input  1  redirect request from the core; single-cycle pulse, may be held.
branch_address  input  ADDR_WIDTH  redirect target.
mem_r_en  output  1  instruction read request to memory.
mem_r_adrs  output  ADDR_WIDTH  read address; equals the current PC.
mem_r_valid  input  1  memory read response strobe; responses return in order, latency at least 1.
mem_data_out  input  DATA_SIZE  read response data.
ir_valid  output  1  head instruction is available.
ir_ready  input  1  core pops the head instruction.
ir_data  output  DATA_SIZE  head instruction word.
ir_pc  output  ADDR_WIDTH  address of the head instruction.
occupancy  output  $clog2(DEPTH)+1  number of buffered entries.

Behaviour:
- State registers:
  - pc (ADDR_WIDTH).
  - Buffer of DEPTH entries {data, addr}, with read/write pointers.
  - count ($clog2(DEPTH)+1 bits).
  - inflight and discard ($clog2(DEPTH)+2 bits each).
  - Per-request address tag queue, DEPTH+... entries, in order; alternatively a registered copy of the issue address, so that ir_pc is correct.
- Reset (asynchronous):
  - pc=RESET_PC; count=inflight=discard=0; pointers=0.
  - Outputs: mem_r_en=0, ir_valid=0, occupancy=0, ir_data=0, ir_pc=0.
- Issue (combinational from registers):
  - mem_r_en = !branch_valid && (count + inflight - discard) < DEPTH.
  - mem_r_adrs = pc.
  - On issue: pc <= pc+1 (wraps from 2^ADDR_WIDTH-1 to 0); inflight increments.
- Response:
  - When mem_r_valid and discard>0: drop the data; discard decrements.
  - When mem_r_valid and discard=0 and no branch this cycle: write {mem_data_out, tag} at the write pointer; count increments.
  - inflight decrements on every response.
- Pop:
  - ir_valid = (count!=0) && !branch_valid.
  - ir_data and ir_pc are driven from the head entry.
  - A pop (ir_valid && ir_ready) advances the read pointer; count decrements.
  - A simultaneous push and pop leaves count unchanged.
- Branch (branch_valid=1), applied next edge:
  - pc <= branch_address; pointers <= 0; count <= 0.
  - discard <= inflight - mem_r_valid.
  - A response arriving in the branch cycle is always dropped.
  - No issue and no pop occur in the branch cycle.
  - First fetch from the target is issued the cycle after branch_valid falls.
- Credit guarantees the buffer never overflows; no push is ever attempted when count=DEPTH.
- mem_r_valid with inflight=0 is a protocol violation; it is ignored and no counter changes.
- Branch held for N cycles: the buffer stays clear and pc stays loaded with the latest branch_address.
- Reset mid-operation clears all state immediately; any later stale responses are ignored by the inflight=0 rule.
- occupancy = count (registered).

Test Plan:
- Reset release with RESET_PC=0, 1-cycle latency memory, ir_ready=0:
  - Issues addresses 0..7, then mem_r_en=0.
  - occupancy=8, ir_valid=1, ir_pc=0.
- Streaming with ir_ready=1 and 1-cycle memory after fill:
  - One issue and one pop per cycle.
  - ir_pc sequence 0,1,2,… consecutive; occupancy constant.
- Branch to 0x100 with 3 requests in flight and 4 entries buffered:
  - Next cycle occupancy=0, discard=3.
  - The 3 stale responses are dropped.
  - First ir_valid shows ir_pc=0x100, data = mem[0x100].
- Branch in the same cycle as a response and a pop:
  - The response is dropped, the pop is ignored, count=0.
  - Subsequent data comes only from the target.
- PC wrap: branch to 0x7FE, ADDR_WIDTH=11:
  - Issued addresses 0x7FE, 0x7FF, 0x000.
  - ir_pc follows the same sequence.
- Reset asserted with 5 in flight, then spurious mem_r_valid pulses after release:
  - All outputs are 0 during reset.
  - After release the spurious pulses are ignored and fetch restarts at RESET_PC.
